note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter width_p, default 24: sample width of the sequenced generator; documentation only, no logic depends on it.
REQ-002 SHALL have parameter depth_p, default 16: note table entries, power of two.
REQ-003 SHALL have parameter freq_width_p, default 16: frequency word width.
REQ-004 SHALL have parameter dur_width_p, default 16: note duration width, counted in samples.
REQ-005 SHALL have port clk_i  in  1: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_i  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_v_i  in  1: table write strobe.
REQ-008 SHALL have port wr_addr_i  in  $clog2(depth_p): table write address.
REQ-009 SHALL have port wr_freq_i  in  freq_width_p: note frequency in Hz.
REQ-010 SHALL have port wr_sw_i  in  4: one-hot wave select (0001 sine, 0010 square, 0100 triangle, 1000 sawtooth).
REQ-011 SHALL have port wr_dur_i  in  dur_width_p: note length in samples.
REQ-012 SHALL have port len_i  in  $clog2(depth_p)+1: number of notes to play.
REQ-013 SHALL have port start_i  in  1: start playback pulse.
REQ-014 SHALL have port stop_i  in  1: abort playback pulse.
REQ-015 SHALL have port loop_i  in  1: restart at note 0 after the last note.
REQ-016 SHALL have port sample_v_i  in  1: generator sample accepted (valid_o & ready_i of frequency_control).
REQ-017 SHALL have port freq_ctrl_o  out  freq_width_p: drives the generator freq_ctrl_i.
REQ-018 SHALL have port sw_o  out  4: drives the generator sw_i; 0000 = mute.
REQ-019 SHALL have port note_idx_o  out  $clog2(depth_p): current note index.
REQ-020 SHALL have port busy_o  out  1: high in every state except IDLE.
REQ-021 SHALL have port done_o  out  1: one-cycle pulse at natural end of a non-looped sequence.

Function
REQ-022 SHALL use states IDLE, LOAD, PLAY and GAP; GAP exists only under REQ-035.
REQ-023 SHALL write the table on any cycle wr_v_i=1, including during playback; the write is visible at that entry's next LOAD.
REQ-024 SHALL, in IDLE with start_i=1 and len_i!=0, latch len_i, set index to 0 and enter LOAD next cycle.
REQ-025 SHALL ignore start_i when len_i=0 and whenever busy_o=1.
REQ-026 SHALL, in LOAD (exactly one cycle), register the entry's freq and sw onto freq_ctrl_o/sw_o, load the counter with the duration (dur=0 treated as 1), and enter PLAY.
REQ-027 SHALL, in PLAY, decrement the counter on each sample_v_i=1; no counting in LOAD or IDLE.
REQ-028 SHALL, on the sample_v_i that decrements the counter from 1: go to LOAD with index+1 if notes remain; go to LOAD with index 0 if last note and loop_i=1 (loop_i sampled that cycle); otherwise go to IDLE, pulse done_o and set sw_o=0000.
REQ-029 SHALL give stop_i priority over all other events: next state IDLE, sw_o=0000, no done_o pulse.
REQ-030 SHALL hold freq_ctrl_o at its last value in IDLE.

Reset
REQ-031 SHALL, while reset_i=1, force state IDLE and freq_ctrl_o=0, sw_o=0000, note_idx_o=0, busy_o=0, done_o=0, counter=0 and latched length=0.
REQ-032 SHALL NOT clear table contents on reset; entries are undefined until written.
REQ-033 SHALL, on reset mid-playback, abort immediately and leave the IDLE state-machine behaviour intact after release.

Configuration
REQ-034 SHALL, without NOTE_SEQ_GAP_EN, transition PLAY directly to LOAD between notes.
REQ-035 SHALL, with NOTE_SEQ_GAP_EN defined, pass between consecutive notes (including the loop wrap) through GAP: sw_o=0000 for gap_samples_p (parameter, default 64) sample_v_i pulses, then LOAD; stop_i in GAP goes to IDLE.

Structure
REQ-036 SHALL take the state enum, the note_entry_t struct (freq, sw, dur) and the mute constant 4'b0000 from the shared package note_seq_pkg.
REQ-037 SHALL implement the table as sub-module note_table: depth_p entries of note_entry_t, one synchronous write port and one combinational read port.

Verification
REQ-038 SHALL verify that after writing entry 0 as {440, 0001, 3} and entry 1 as {880, 0010, 2}, start with len=2 and continuous sample_v_i gives sw_o=0001 for 3 samples, then 0010 for 2 samples, then done_o for one cycle and sw_o=0000.
REQ-039 SHALL verify that the same sequence with loop_i=1 returns note_idx_o to 0 after 5 samples with busy_o staying high and no done_o.
REQ-040 SHALL verify that stop_i asserted together with sample_v_i mid-note gives IDLE next cycle, sw_o=0000 and no done_o.
REQ-041 SHALL verify that start with len_i=0, or start while busy, leaves busy_o and note_idx_o unchanged.
REQ-042 SHALL verify that an entry with dur=0 plays for exactly 1 sample, and that with sample_v_i held low for 100 cycles the counter does not advance.
REQ-043 SHALL verify that reset_i asserted mid-PLAY clears all outputs asynchronously, and that under NOTE_SEQ_GAP_EN with gap_samples_p=4 sw_o=0000 for 4 samples between notes.

Source files
------------

// File: rtl/note_seq_pkg.sv
// ----------------------------------------------------------------------------
// note_seq_pkg
// Types and constants shared by the note sequencer and its note table.
//   state_e      : sequencer state encoding (IDLE / LOAD / PLAY / GAP)
//   note_entry_t : one note table entry {freq, sw, dur}
//   SW_MUTE      : wave-select value that silences the generator
// Entry field widths are fixed here; the sequencer's freq_width_p and
// dur_width_p must not exceed NOTE_FREQ_W / NOTE_DUR_W.
// ----------------------------------------------------------------------------
package note_seq_pkg;

    localparam int NOTE_FREQ_W = 16;
    localparam int NOTE_DUR_W  = 16;

    localparam logic [3:0] SW_MUTE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [NOTE_FREQ_W-1:0] freq;
        logic [3:0]             sw;
        logic [NOTE_DUR_W-1:0]  dur;
    } note_entry_t;

endpackage

// File: rtl/note_table.sv
// ----------------------------------------------------------------------------
// note_table
// depth_p-entry note storage: one synchronous write port, one combinational
// read port.
//   i_clk     : clock, writes on rising edge
//   i_wr_v    : write strobe
//   i_wr_addr : write address
//   i_wr_data : entry to write
//   i_rd_addr : read address
//   o_rd_data : entry at i_rd_addr (combinational)
// ----------------------------------------------------------------------------
module note_table
    import note_seq_pkg::*;
#(
    parameter int depth_p = 16
) (
    input  logic                       i_clk,
    input  logic                       i_wr_v,
    input  logic [$clog2(depth_p)-1:0] i_wr_addr,
    input  note_entry_t                i_wr_data,
    input  logic [$clog2(depth_p)-1:0] i_rd_addr,
    output note_entry_t                o_rd_data
);

    note_entry_t r_mem [depth_p];

    // NOTE: storage has no reset; contents are undefined until written, which
    // keeps the array mappable onto plain RAM / register-file cells.
    always_ff @(posedge i_clk) begin
        if (i_wr_v) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// ----------------------------------------------------------------------------
// note_sequencer
// Plays a programmed list of notes into a waveform generator. Each note sets
// the generator frequency and wave select for a number of accepted samples.
//   clk_i, reset_i : clock, async active-high reset
//   wr_*_i         : note table write port (freq, one-hot wave, duration)
//   len_i          : number of notes to play (0 = start ignored)
//   start_i/stop_i : start playback / abort playback (stop wins)
//   loop_i         : wrap to note 0 after the last note
//   sample_v_i     : generator accepted a sample (duration tick)
//   freq_ctrl_o    : generator frequency word (held in IDLE)
//   sw_o           : generator wave select, 0000 = mute
//   note_idx_o     : index of current note
//   busy_o         : not IDLE
//   done_o         : one-cycle pulse when a non-looped sequence ends
// Build option: define NOTE_SEQ_GAP_EN to insert a muted gap of
// gap_samples_p samples between consecutive notes (including loop wrap).
// depth_p must be a power of two, at least 2.
// ----------------------------------------------------------------------------
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int width_p      = 24,  // sample width of the generator, informational
    parameter int depth_p      = 16,
    parameter int freq_width_p = 16,
    parameter int dur_width_p  = 16
`ifdef NOTE_SEQ_GAP_EN
    , parameter int gap_samples_p = 64
`endif
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         wr_v_i,
    input  logic [$clog2(depth_p)-1:0]   wr_addr_i,
    input  logic [freq_width_p-1:0]      wr_freq_i,
    input  logic [3:0]                   wr_sw_i,
    input  logic [dur_width_p-1:0]       wr_dur_i,
    input  logic [$clog2(depth_p):0]     len_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         loop_i,
    input  logic                         sample_v_i,
    output logic [freq_width_p-1:0]      freq_ctrl_o,
    output logic [3:0]                   sw_o,
    output logic [$clog2(depth_p)-1:0]   note_idx_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int IDX_W = $clog2(depth_p);
    localparam int LEN_W = IDX_W + 1;

`ifdef NOTE_SEQ_GAP_EN
    // A zero-length gap would never reach its terminal count; clamp to 1.
    localparam int GAP_LOAD = (gap_samples_p < 1) ? 1 : gap_samples_p;
    localparam int GAP_W    = $clog2(GAP_LOAD + 1);
`endif

    state_e                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [LEN_W-1:0]        r_len;
    logic [dur_width_p-1:0]  r_cnt;
    logic [freq_width_p-1:0] r_freq;
    logic [3:0]              r_sw;
    logic                    r_done;
`ifdef NOTE_SEQ_GAP_EN
    logic [GAP_W-1:0]        r_gap_cnt;
`endif

    note_entry_t             w_wr_entry;
    note_entry_t             w_rd_entry;
    logic                    w_last;

    assign w_wr_entry.freq = NOTE_FREQ_W'(wr_freq_i);
    assign w_wr_entry.sw   = wr_sw_i;
    assign w_wr_entry.dur  = NOTE_DUR_W'(wr_dur_i);

    note_table #(
        .depth_p (depth_p)
    ) u_table (
        .i_clk     (clk_i),
        .i_wr_v    (wr_v_i),
        .i_wr_addr (wr_addr_i),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_entry)
    );

    // Current note is the final one of the latched sequence length.
    assign w_last = ({1'b0, r_idx} == (r_len - 1'b1));

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_freq    <= '0;
            r_sw      <= SW_MUTE;
            r_done    <= 1'b0;
`ifdef NOTE_SEQ_GAP_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (stop_i && (r_state != ST_IDLE)) begin
                // Abort outranks note end, loop wrap and gap expiry.
                r_state <= ST_IDLE;
                r_sw    <= SW_MUTE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && (len_i != '0)) begin
                            r_len   <= len_i;
                            r_idx   <= '0;
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_freq  <= freq_width_p'(w_rd_entry.freq);
                        r_sw    <= w_rd_entry.sw;
                        // A zero duration still plays for one sample.
                        r_cnt   <= (w_rd_entry.dur == '0) ? dur_width_p'(1)
                                                          : dur_width_p'(w_rd_entry.dur);
                        r_state <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (sample_v_i) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == dur_width_p'(1)) begin
                                if (w_last && !loop_i) begin
                                    r_state <= ST_IDLE;
                                    r_sw    <= SW_MUTE;
                                    r_done  <= 1'b1;
                                end else begin
                                    // Index advances now so LOAD reads the next entry.
                                    r_idx <= w_last ? '0 : r_idx + 1'b1;
`ifdef NOTE_SEQ_GAP_EN
                                    r_state   <= ST_GAP;
                                    r_sw      <= SW_MUTE;
                                    r_gap_cnt <= GAP_W'(GAP_LOAD);
`else
                                    r_state <= ST_LOAD;
`endif
                                end
                            end
                        end
                    end
`ifdef NOTE_SEQ_GAP_EN
                    ST_GAP: begin
                        if (sample_v_i) begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                            if (r_gap_cnt == GAP_W'(1)) begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                        r_sw    <= SW_MUTE;
                    end
                endcase
            end
        end
    end

    assign freq_ctrl_o = r_freq;
    assign sw_o        = r_sw;
    assign note_idx_o  = r_idx;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// ----------------------------------------------------------------------------
// tb_note_sequencer
// Directed testbench for note_sequencer. Inputs change on the falling edge and
// outputs are observed on the falling edge, half a cycle after the rising
// edge that updated them. Define NOTE_SEQ_GAP_EN to also exercise the gap.
// ----------------------------------------------------------------------------
module tb_note_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        wr_v_i;
    logic [3:0]  wr_addr_i;
    logic [15:0] wr_freq_i;
    logic [3:0]  wr_sw_i;
    logic [15:0] wr_dur_i;
    logic [4:0]  len_i;
    logic        start_i;
    logic        stop_i;
    logic        loop_i;
    logic        sample_v_i;
    logic [15:0] freq_ctrl_o;
    logic [3:0]  sw_o;
    logic [3:0]  note_idx_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

`ifdef NOTE_SEQ_GAP_EN
    note_sequencer #(.gap_samples_p(4)) dut (
`else
    note_sequencer dut (
`endif
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_v_i      (wr_v_i),
        .wr_addr_i   (wr_addr_i),
        .wr_freq_i   (wr_freq_i),
        .wr_sw_i     (wr_sw_i),
        .wr_dur_i    (wr_dur_i),
        .len_i       (len_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .loop_i      (loop_i),
        .sample_v_i  (sample_v_i),
        .freq_ctrl_o (freq_ctrl_o),
        .sw_o        (sw_o),
        .note_idx_o  (note_idx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [15:0] freq,
                               input logic [3:0] sw, input logic [15:0] dur);
        wr_v_i    = 1'b1;
        wr_addr_i = addr;
        wr_freq_i = freq;
        wr_sw_i   = sw;
        wr_dur_i  = dur;
        tick();
        wr_v_i    = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        wr_v_i = 1'b0; wr_addr_i = '0; wr_freq_i = '0; wr_sw_i = '0; wr_dur_i = '0;
        len_i = '0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; sample_v_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({freq_ctrl_o, sw_o, note_idx_o, busy_o, done_o} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: freq=%0d sw=%b idx=%0d busy=%b done=%b, expected all zero",
                     freq_ctrl_o, sw_o, note_idx_o, busy_o, done_o);
        end
        reset_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b, expected 0", busy_o);
        end
    endtask

    // Entry 0 {440,0001,3}, entry 1 {880,0010,2}, len 2, continuous samples.
    task automatic test_basic_sequence();
        logic [3:0]  e_sw   [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h0, 4'h0};
        logic [3:0]  e_idx  [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        logic        e_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        e_done [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] e_freq [9] = '{16'd0, 16'd440, 16'd440, 16'd440, 16'd440,
                                    16'd880, 16'd880, 16'd880, 16'd880};
        write_entry(4'd0, 16'd440, 4'b0001, 16'd3);
        write_entry(4'd1, 16'd880, 4'b0010, 16'd2);
        len_i      = 5'd2;
        sample_v_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start_i = (i == 0);
            tick();
            checks++;
            if ({busy_o, done_o, note_idx_o, sw_o, freq_ctrl_o} !==
                {e_busy[i], e_done[i], e_idx[i], e_sw[i], e_freq[i]}) begin
                failures++;
                $display("FAIL basic_cycle%0d: busy=%b done=%b idx=%0d sw=%b freq=%0d, expected busy=%b done=%b idx=%0d sw=%b freq=%0d",
                         i + 1, busy_o, done_o, note_idx_o, sw_o, freq_ctrl_o,
                         e_busy[i], e_done[i], e_idx[i], e_sw[i], e_freq[i]);
            end
        end
        start_i    = 1'b0;
        sample_v_i = 1'b0;
    endtask

    // Idle with note_idx_o left at 1 by the previous sequence.
    task automatic test_start_len_zero();
        len_i   = 5'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, note_idx_o} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL start_len0: busy=%b idx=%0d, expected busy=0 idx=1", busy_o, note_idx_o);
        end
    endtask

    task automatic test_loop();
        logic [3:0]  e_sw   [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h1};
        logic [3:0]  e_idx  [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        len_i      = 5'd2;
        loop_i     = 1'b1;
        sample_v_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start_i = (i == 0);
            tick();
            checks++;
            if ({busy_o, done_o, note_idx_o, sw_o} !== {1'b1, 1'b0, e_idx[i], e_sw[i]}) begin
                failures++;
                $display("FAIL loop_cycle%0d: busy=%b done=%b idx=%0d sw=%b, expected busy=1 done=0 idx=%0d sw=%b",
                         i + 1, busy_o, done_o, note_idx_o, sw_o, e_idx[i], e_sw[i]);
            end
        end
        start_i = 1'b0;
        stop_i  = 1'b1;
        tick();
        stop_i  = 1'b0;
        loop_i  = 1'b0;
        checks++;
        if ({busy_o, done_o, sw_o} !== {1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL loop_stop: busy=%b done=%b sw=%b, expected busy=0 done=0 sw=0000",
                     busy_o, done_o, sw_o);
        end
        sample_v_i = 1'b0;
    endtask

    task automatic test_stop();
        // Mid-note stop coinciding with a sample.
        len_i      = 5'd2;
        sample_v_i = 1'b1;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        tick();
        tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if ({busy_o, done_o, sw_o} !== {1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL stop_mid_note: busy=%b done=%b sw=%b, expected busy=0 done=0 sw=0000",
                     busy_o, done_o, sw_o);
        end
        tick();
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            failures++;
            $display("FAIL stop_mid_note_after: busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
        // Stop on the sample that would end a single-note sequence.
        len_i   = 5'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if ({busy_o, done_o, sw_o} !== {1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL stop_on_last_sample: busy=%b done=%b sw=%b, expected busy=0 done=0 sw=0000",
                     busy_o, done_o, sw_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_on_last_sample_done: done=%b, expected 0", done_o);
        end
        sample_v_i = 1'b0;
    endtask

    task automatic test_start_while_busy();
        len_i   = 5'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        len_i   = 5'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if ({busy_o, note_idx_o, sw_o} !== {1'b1, 4'd0, 4'h1}) begin
            failures++;
            $display("FAIL start_busy: busy=%b idx=%0d sw=%b, expected busy=1 idx=0 sw=0001",
                     busy_o, note_idx_o, sw_o);
        end
        // Latched length must still be 2: the first note moves on to note 1.
        sample_v_i = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({busy_o, note_idx_o} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL start_busy_len_kept: busy=%b idx=%0d, expected busy=1 idx=1",
                     busy_o, note_idx_o);
        end
        sample_v_i = 1'b0;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    task automatic test_zero_duration_and_hold();
        int bad_cycles = 0;
        write_entry(4'd0, 16'd1000, 4'b0100, 16'd0);
        len_i   = 5'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, sw_o, freq_ctrl_o} !== {1'b1, 4'h4, 16'd1000}) begin
            failures++;
            $display("FAIL zero_dur_play: busy=%b sw=%b freq=%0d, expected busy=1 sw=0100 freq=1000",
                     busy_o, sw_o, freq_ctrl_o);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy_o !== 1'b1 || sw_o !== 4'h4 || done_o !== 1'b0) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            failures++;
            $display("FAIL no_sample_hold: cycles_off_note=%0d, expected 0", bad_cycles);
        end
        sample_v_i = 1'b1;
        tick();
        sample_v_i = 1'b0;
        checks++;
        if ({busy_o, done_o, sw_o} !== {1'b0, 1'b1, 4'h0}) begin
            failures++;
            $display("FAIL zero_dur_one_sample: busy=%b done=%b sw=%b, expected busy=0 done=1 sw=0000",
                     busy_o, done_o, sw_o);
        end
    endtask

    task automatic test_async_reset();
        write_entry(4'd0, 16'd440, 4'b0001, 16'd3);
        len_i      = 5'd2;
        sample_v_i = 1'b1;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        tick();
        sample_v_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({freq_ctrl_o, sw_o, note_idx_o, busy_o, done_o} !== 26'd0) begin
            failures++;
            $display("FAIL async_reset: freq=%0d sw=%b idx=%0d busy=%b done=%b, expected all zero",
                     freq_ctrl_o, sw_o, note_idx_o, busy_o, done_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, note_idx_o, sw_o, freq_ctrl_o} !== {1'b1, 4'd0, 4'h1, 16'd440}) begin
            failures++;
            $display("FAIL restart_after_reset: busy=%b idx=%0d sw=%b freq=%0d, expected busy=1 idx=0 sw=0001 freq=440",
                     busy_o, note_idx_o, sw_o, freq_ctrl_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

`ifdef NOTE_SEQ_GAP_EN
    task automatic test_gap();
        logic [3:0] e_sw  [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
        logic [3:0] e_idx [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        len_i      = 5'd2;
        sample_v_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 0);
            tick();
            checks++;
            if ({busy_o, note_idx_o, sw_o} !== {1'b1, e_idx[i], e_sw[i]}) begin
                failures++;
                $display("FAIL gap_cycle%0d: busy=%b idx=%0d sw=%b, expected busy=1 idx=%0d sw=%b",
                         i + 1, busy_o, note_idx_o, sw_o, e_idx[i], e_sw[i]);
            end
        end
        start_i    = 1'b0;
        sample_v_i = 1'b0;
        stop_i     = 1'b1;
        tick();
        stop_i     = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_sequence();
        test_start_len_zero();
        test_loop();
        test_stop();
        test_start_while_busy();
        test_zero_duration_and_hold();
        test_async_reset();
`ifdef NOTE_SEQ_GAP_EN
        test_gap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
